// File: rtl/bme280_i2c_slave_pkg.sv
// Shared constants and FSM state encoding for the BME280-style I2C slave.
package bme280_i2c_slave_pkg;

   localparam logic [6:0]  SLADDR_DEF = 7'b111_0110;
   localparam int unsigned I2C_BITS   = 8;
   localparam int unsigned CNT_W      = 4;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_PTR,
      S_PTR_ACK,
      S_WDATA,
      S_WDATA_ACK,
      S_RDATA,
      S_RDATA_ACK,
      S_IGNORE
   } state_t;

endpackage

// File: rtl/sync_reg.sv
// Multi-flop level synchronizer for an asynchronous single-bit input.
// Ports: Clk, Rst_n (async active-low), i_d raw input, o_q synchronized output.
module sync_reg #(
   parameter int unsigned NSTAGES = 2,
   parameter logic        RST_VAL = 1'b1
) (
   input  logic Clk,
   input  logic Rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [NSTAGES-1:0] r_sync;

   // Shift chain; stage 0 samples the pad.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_sync <= {NSTAGES{RST_VAL}};
      end else begin
         r_sync[0] <= i_d;
         for (int i = 1; i < int'(NSTAGES); i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   assign o_q = r_sync[NSTAGES-1];

endmodule

// File: rtl/bme280_i2c_slave.sv
// I2C slave exposing an 8-bit register pointer/strobe interface (BME280 style).
// Ports:
//   Clk, Rst_n          : system clock, async active-low reset
//   SclPadIn, SdaPadIn  : raw pad levels
//   SdaPadOut, SdaPadEn : open-drain SDA drive (En active-low, Out always 0)
//   RegAddr             : register pointer
//   RegWdata, RegWr     : write data and one-cycle write strobe
//   RegRdata, RegRd     : combinational read data and its capture strobe
//   Busy                : slave addressed, until STOP
module bme280_i2c_slave
   import bme280_i2c_slave_pkg::*;
#(
   parameter logic [6:0]  SLADDR  = SLADDR_DEF,
   parameter int unsigned NSTAGES = 2
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       SclPadIn,
   input  logic       SdaPadIn,
   output logic       SdaPadOut,
   output logic       SdaPadEn,
   output logic [7:0] RegAddr,
   output logic [7:0] RegWdata,
   output logic       RegWr,
   input  logic [7:0] RegRdata,
   output logic       RegRd,
   output logic       Busy
);

   localparam logic [CNT_W-1:0] BITS_C = CNT_W'(I2C_BITS);

   logic w_scl_s, w_sda_s;
   logic r_scl_d, r_sda_d;
   logic w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
   logic w_start, w_stop;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_bit_cnt, w_cnt_nxt;
   logic [7:0]       r_shift, w_shift_nxt;
   logic             r_rw, w_rw_nxt;
   logic             r_mnack, w_mnack_nxt;
   logic             r_sda_en, w_sda_en_nxt;
   logic [7:0]       r_addr, w_addr_nxt;
   logic [7:0]       r_wdata, w_wdata_nxt;
   logic             r_wr, w_wr_nxt;
   logic             r_rd, w_rd_nxt;
   logic             r_busy, w_busy_nxt;

   sync_reg #(.NSTAGES(NSTAGES), .RST_VAL(1'b1)) u_sync_scl (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .i_d   (SclPadIn),
      .o_q   (w_scl_s)
   );

   sync_reg #(.NSTAGES(NSTAGES), .RST_VAL(1'b1)) u_sync_sda (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .i_d   (SdaPadIn),
      .o_q   (w_sda_s)
   );

   // Previous synchronized levels for edge detection.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_scl_d <= 1'b1;
         r_sda_d <= 1'b1;
      end else begin
         r_scl_d <= w_scl_s;
         r_sda_d <= w_sda_s;
      end
   end

   assign w_scl_rise = w_scl_s & ~r_scl_d;
   assign w_scl_fall = ~w_scl_s & r_scl_d;
   assign w_sda_rise = w_sda_s & ~r_sda_d;
   assign w_sda_fall = ~w_sda_s & r_sda_d;
   // SCL must be high both before and after the SDA edge.
   assign w_start    = w_sda_fall & w_scl_s & r_scl_d;
   assign w_stop     = w_sda_rise & w_scl_s & r_scl_d;

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_bit_cnt;
      w_shift_nxt  = r_shift;
      w_rw_nxt     = r_rw;
      w_mnack_nxt  = r_mnack;
      w_sda_en_nxt = r_sda_en;
      w_wdata_nxt  = r_wdata;
      w_wr_nxt     = 1'b0;
      w_rd_nxt     = 1'b0;
      w_busy_nxt   = r_busy;
      // Pointer advances the cycle after any write or read strobe.
      w_addr_nxt   = (r_wr | r_rd) ? r_addr + 8'd1 : r_addr;

      if (w_stop) begin
         w_state_nxt  = S_IDLE;
         w_cnt_nxt    = '0;
         w_sda_en_nxt = 1'b1;
         w_busy_nxt   = 1'b0;
      end else if (w_start) begin
         w_state_nxt  = S_ADDR;
         w_cnt_nxt    = '0;
         w_sda_en_nxt = 1'b1;
      end else begin
         unique case (r_state)
            S_ADDR, S_PTR, S_WDATA: begin
               if (w_scl_rise && (r_bit_cnt < BITS_C)) begin
                  w_shift_nxt = {r_shift[6:0], w_sda_s};
                  w_cnt_nxt   = r_bit_cnt + CNT_W'(1);
               end
               // Byte complete: act on the fall ending the 8th clock.
               if (w_scl_fall && (r_bit_cnt == BITS_C)) begin
                  unique case (r_state)
                     S_ADDR: begin
                        if (r_shift[7:1] == SLADDR) begin
                           w_rw_nxt     = r_shift[0];
                           w_sda_en_nxt = 1'b0;
                           w_busy_nxt   = 1'b1;
                           w_state_nxt  = S_ADDR_ACK;
                        end else begin
                           w_busy_nxt  = 1'b0;
                           w_state_nxt = S_IGNORE;
                        end
                     end
                     S_PTR: begin
                        w_addr_nxt   = r_shift;
                        w_sda_en_nxt = 1'b0;
                        w_state_nxt  = S_PTR_ACK;
                     end
                     default: begin
                        w_wdata_nxt  = r_shift;
                        w_wr_nxt     = 1'b1;
                        w_sda_en_nxt = 1'b0;
                        w_state_nxt  = S_WDATA_ACK;
                     end
                  endcase
               end
            end

            S_ADDR_ACK: begin
               if (w_scl_fall) begin
                  w_cnt_nxt = '0;
                  if (r_rw) begin
                     w_shift_nxt  = RegRdata;
                     w_rd_nxt     = 1'b1;
                     w_sda_en_nxt = RegRdata[7];
                     w_state_nxt  = S_RDATA;
                  end else begin
                     w_sda_en_nxt = 1'b1;
                     w_state_nxt  = S_PTR;
                  end
               end
            end

            S_PTR_ACK, S_WDATA_ACK: begin
               if (w_scl_fall) begin
                  w_cnt_nxt    = '0;
                  w_sda_en_nxt = 1'b1;
                  w_state_nxt  = S_WDATA;
               end
            end

            S_RDATA: begin
               if (w_scl_rise && (r_bit_cnt < BITS_C)) begin
                  w_cnt_nxt = r_bit_cnt + CNT_W'(1);
               end
               if (w_scl_fall && (r_bit_cnt != '0)) begin
                  if (r_bit_cnt == BITS_C) begin
                     // Release for the master's acknowledge.
                     w_sda_en_nxt = 1'b1;
                     w_state_nxt  = S_RDATA_ACK;
                  end else begin
                     w_shift_nxt  = {r_shift[6:0], 1'b1};
                     w_sda_en_nxt = r_shift[6];
                  end
               end
            end

            S_RDATA_ACK: begin
               if (w_scl_rise) begin
                  w_mnack_nxt = w_sda_s;
               end
               if (w_scl_fall) begin
                  w_cnt_nxt = '0;
                  if (!r_mnack) begin
                     w_shift_nxt  = RegRdata;
                     w_rd_nxt     = 1'b1;
                     w_sda_en_nxt = RegRdata[7];
                     w_state_nxt  = S_RDATA;
                  end else begin
                     w_sda_en_nxt = 1'b1;
                     w_state_nxt  = S_IGNORE;
                  end
               end
            end

            default: begin
               // IDLE and IGNORE wait for START/STOP only.
            end
         endcase
      end
   end

   // State and registered outputs.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= '0;
         r_shift   <= 8'h00;
         r_rw      <= 1'b0;
         r_mnack   <= 1'b1;
         r_sda_en  <= 1'b1;
         r_addr    <= 8'h00;
         r_wdata   <= 8'h00;
         r_wr      <= 1'b0;
         r_rd      <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_cnt_nxt;
         r_shift   <= w_shift_nxt;
         r_rw      <= w_rw_nxt;
         r_mnack   <= w_mnack_nxt;
         r_sda_en  <= w_sda_en_nxt;
         r_addr    <= w_addr_nxt;
         r_wdata   <= w_wdata_nxt;
         r_wr      <= w_wr_nxt;
         r_rd      <= w_rd_nxt;
         r_busy    <= w_busy_nxt;
      end
   end

   assign SdaPadOut = 1'b0;
   assign SdaPadEn  = r_sda_en;
   assign RegAddr   = r_addr;
   assign RegWdata  = r_wdata;
   assign RegWr     = r_wr;
   assign RegRd     = r_rd;
   assign Busy      = r_busy;

endmodule

// File: tb/tb_bme280_i2c_slave.sv
// Directed bench for bme280_i2c_slave: bit-banged I2C master, register model,
// strobe monitor and hand-computed expectations.
module tb_bme280_i2c_slave;

   localparam int H = 5;
   localparam int Q = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       sda_line;
   logic       sda_out, sda_en;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic       reg_wr, reg_rd, busy;
   logic [7:0] mem [256];

   int n_chk = 0;
   int n_pass = 0;

   logic [7:0] wr_addr_q[$];
   logic [7:0] wr_data_q[$];
   int         rd_cnt = 0;
   int         drv_cnt = 0;

   always #5 clk = ~clk;

   // Open-drain bus: either side may pull low.
   assign sda_line  = m_sda & (sda_en | sda_out);
   assign reg_rdata = mem[reg_addr];

   bme280_i2c_slave dut (
      .Clk       (clk),
      .Rst_n     (rst_n),
      .SclPadIn  (scl),
      .SdaPadIn  (sda_line),
      .SdaPadOut (sda_out),
      .SdaPadEn  (sda_en),
      .RegAddr   (reg_addr),
      .RegWdata  (reg_wdata),
      .RegWr     (reg_wr),
      .RegRdata  (reg_rdata),
      .RegRd     (reg_rd),
      .Busy      (busy)
   );

   // Strobe/drive monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (reg_wr) begin
            wr_addr_q.push_back(reg_addr);
            wr_data_q.push_back(reg_wdata);
         end
         if (reg_rd) rd_cnt++;
         if (!sda_en) drv_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start;
      wait_cyc(H); m_sda = 1'b1;
      wait_cyc(H); scl = 1'b1;
      wait_cyc(Q); m_sda = 1'b0;
      wait_cyc(Q); scl = 1'b0;
   endtask

   task automatic i2c_stop;
      wait_cyc(H); m_sda = 1'b0;
      wait_cyc(H); scl = 1'b1;
      wait_cyc(Q); m_sda = 1'b1;
      wait_cyc(Q);
   endtask

   task automatic write_bit(input logic b);
      wait_cyc(H); m_sda = b;
      wait_cyc(H); scl = 1'b1;
      wait_cyc(Q); scl = 1'b0;
   endtask

   task automatic read_bit(output logic b);
      wait_cyc(H); m_sda = 1'b1;
      wait_cyc(H); scl = 1'b1;
      wait_cyc(H); b = sda_line;
      wait_cyc(H); scl = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(ack);
   endtask

   task automatic single_write(input string tag);
      logic ack;
      int   base;
      base = wr_addr_q.size();
      i2c_start;
      write_byte(8'hEC, ack); chk({tag, "_ack_addr"}, 32'(ack), 32'd0);
      chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
      write_byte(8'hF4, ack); chk({tag, "_ack_ptr"}, 32'(ack), 32'd0);
      write_byte(8'h27, ack); chk({tag, "_ack_data"}, 32'(ack), 32'd0);
      i2c_stop;
      chk({tag, "_wr_count"}, 32'(wr_addr_q.size() - base), 32'd1);
      chk({tag, "_wr_addr"}, 32'(wr_addr_q[base]), 32'hF4);
      chk({tag, "_wr_data"}, 32'(wr_data_q[base]), 32'h27);
      chk({tag, "_ptr_end"}, 32'(reg_addr), 32'hF5);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic       ack;
      logic [7:0] d;
      int         base, rbase, dbase;

      for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'hA5);
      mem[8'hF7] = 8'h65;
      mem[8'hF8] = 8'h5A;
      mem[8'hF9] = 8'hC0;

      // Reset values.
      wait_cyc(4);
      chk("rst_sda_en", 32'(sda_en), 32'd1);
      chk("rst_sda_out", 32'(sda_out), 32'd0);
      chk("rst_addr", 32'(reg_addr), 32'h00);
      chk("rst_wdata", 32'(reg_wdata), 32'h00);
      chk("rst_wr", 32'(reg_wr), 32'd0);
      chk("rst_rd", 32'(reg_rd), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      wait_cyc(10);

      // Single write.
      single_write("sw");

      // Burst read F7..F9.
      rbase = rd_cnt;
      i2c_start;
      write_byte(8'hEC, ack); chk("br_ack_waddr", 32'(ack), 32'd0);
      write_byte(8'hF7, ack); chk("br_ack_ptr", 32'(ack), 32'd0);
      i2c_start;
      write_byte(8'hED, ack); chk("br_ack_raddr", 32'(ack), 32'd0);
      read_byte(d, 1'b0); chk("br_byte0", 32'(d), 32'h65);
      read_byte(d, 1'b0); chk("br_byte1", 32'(d), 32'h5A);
      read_byte(d, 1'b1); chk("br_byte2", 32'(d), 32'hC0);
      i2c_stop;
      chk("br_rd_count", 32'(rd_cnt - rbase), 32'd3);
      chk("br_ptr_end", 32'(reg_addr), 32'hFA);
      chk("br_busy_end", 32'(busy), 32'd0);

      // Address mismatch.
      base  = wr_addr_q.size();
      dbase = drv_cnt;
      i2c_start;
      write_byte(8'hEE, ack); chk("mm_nack_addr", 32'(ack), 32'd1);
      chk("mm_busy_mid", 32'(busy), 32'd0);
      write_byte(8'h10, ack); chk("mm_nack_data", 32'(ack), 32'd1);
      i2c_stop;
      chk("mm_no_drive", 32'(drv_cnt - dbase), 32'd0);
      chk("mm_no_wr", 32'(wr_addr_q.size() - base), 32'd0);
      chk("mm_busy_end", 32'(busy), 32'd0);

      // Pointer wrap FF -> 00.
      base = wr_addr_q.size();
      i2c_start;
      write_byte(8'hEC, ack); chk("wr_ack_addr", 32'(ack), 32'd0);
      write_byte(8'hFF, ack); chk("wr_ack_ptr", 32'(ack), 32'd0);
      write_byte(8'h11, ack); chk("wr_ack_d0", 32'(ack), 32'd0);
      write_byte(8'h22, ack); chk("wr_ack_d1", 32'(ack), 32'd0);
      i2c_stop;
      chk("wr_count", 32'(wr_addr_q.size() - base), 32'd2);
      chk("wr_addr0", 32'(wr_addr_q[base]), 32'hFF);
      chk("wr_data0", 32'(wr_data_q[base]), 32'h11);
      chk("wr_addr1", 32'(wr_addr_q[base+1]), 32'h00);
      chk("wr_data1", 32'(wr_data_q[base+1]), 32'h22);
      chk("wr_ptr_end", 32'(reg_addr), 32'h01);

      // Reset while the slave drives the 0 MSB of 0x65.
      i2c_start;
      write_byte(8'hEC, ack);
      write_byte(8'hF7, ack);
      i2c_start;
      write_byte(8'hED, ack); chk("rr_ack_raddr", 32'(ack), 32'd0);
      wait_cyc(H);
      chk("rr_driving", 32'(sda_en), 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rr_sda_released", 32'(sda_en), 32'd1);
      m_sda = 1'b1;
      scl   = 1'b1;
      wait_cyc(4);
      chk("rr_addr_rst", 32'(reg_addr), 32'h00);
      chk("rr_busy_rst", 32'(busy), 32'd0);
      rst_n = 1'b1;
      wait_cyc(10);
      single_write("rr_sw");

      // STOP after four data bits: byte discarded.
      base = wr_addr_q.size();
      i2c_start;
      write_byte(8'hEC, ack); chk("ab_ack_addr", 32'(ack), 32'd0);
      write_byte(8'hF4, ack); chk("ab_ack_ptr", 32'(ack), 32'd0);
      write_bit(1'b0);
      write_bit(1'b0);
      write_bit(1'b1);
      write_bit(1'b0);
      i2c_stop;
      chk("ab_no_wr", 32'(wr_addr_q.size() - base), 32'd0);
      chk("ab_ptr", 32'(reg_addr), 32'hF4);
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_sda_en", 32'(sda_en), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/bme280_i2c_slave.md
BME280_I2C_SLAVE -- requirements
Module: bme280_i2c_slave

Interface
REQ-001 The block SHALL have parameter SLADDR, default 7'b111_0110, the 7-bit I2C address it responds to.
REQ-002 The block SHALL have parameter NSTAGES, default 2, the synchronizer depth for SCL/SDA inputs.
REQ-003 Clk  input  1  system clock (100 MHz); the block SHALL use this single clock.
REQ-004 Rst_n  input  1  reset; the block SHALL use an asynchronous, active-low reset.
REQ-005 SclPadIn  input  1  raw SCL pad level.
REQ-006 SdaPadIn  input  1  raw SDA pad level.
REQ-007 SdaPadOut  output  1  SDA drive value, always 0 when driving.
REQ-008 SdaPadEn  output  1  SDA output enable, active-low: 1 releases SDA (Hi-Z), 0 drives SdaPadOut.
REQ-009 RegAddr  output  8  register pointer.
REQ-010 RegWdata  output  8  write data, valid while RegWr=1.
REQ-011 RegWr  output  1  one-cycle register write strobe.
REQ-012 RegRdata  input  8  combinational read data for RegAddr.
REQ-013 RegRd  output  1  one-cycle strobe marking capture of RegRdata.
REQ-014 Busy  output  1  high from START to STOP while this slave is addressed.

Function
REQ-015 The block SHALL synchronize SCL and SDA through NSTAGES flops and derive single-cycle rise/fall events from the synchronized levels.
REQ-016 START SHALL be SDA fall while SCL high; STOP SHALL be SDA rise while SCL high; both SHALL be detected in every state.
REQ-017 States SHALL be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK and IGNORE.
REQ-018 START (including repeated START) SHALL enter ADDR with bit counter 0 and SHALL keep RegAddr unchanged.
REQ-019 STOP SHALL enter IDLE, release SDA and clear Busy.
REQ-020 Bits SHALL be sampled on the SCL rise event, MSB first, 8 bits per byte.
REQ-021 SDA SHALL change only on the SCL fall event.
REQ-022 Address handling:
- Address byte equal to {SLADDR,R/W} SHALL be ACKed: drive 0 for the 9th clock.
- Mismatch SHALL enter IGNORE with SDA released until START or STOP.
REQ-023 After a write-address ACK, the first byte SHALL load RegAddr (PTR), followed by ACK.
REQ-024 Each further write byte SHALL produce exactly one RegWr pulse with RegWdata = the byte and RegAddr = the current pointer.
REQ-025 The pointer SHALL increment by 1 in the cycle after RegWr, wrapping 8'hFF to 8'h00; each write byte SHALL be ACKed.
REQ-026 Read byte fetch:
- Trigger: the SCL fall that ends a read-address ACK or a master ACK.
- Action: the shift register loads RegRdata, RegRd pulses for one cycle, and the pointer increments (with wrap) the next cycle.
REQ-027 In RDATA the block SHALL drive 0 for a 0 bit and release SDA for a 1 bit.
REQ-028 At the 9th clock of a read byte the block SHALL release SDA and sample the master's acknowledge:
- Master ACK (0): fetch the next byte.
- Master NACK (1): enter IGNORE.
REQ-029 A STOP or START before the 8th bit of a byte SHALL discard the partial byte, with no RegWr and no pointer change.
REQ-030 The ACK drive SHALL be released on the SCL fall that ends the 9th clock.

Reset
REQ-031 On Rst_n=0 the block SHALL go, asynchronously, to state IDLE with:
- SdaPadEn=1, SdaPadOut=0
- RegAddr=8'h00, RegWdata=8'h00
- RegWr=0, RegRd=0, Busy=0
- synchronizers loaded with 1
REQ-032 After Rst_n rises, the block SHALL respond correctly to the next START.

Structure
REQ-033 States, SLADDR default and the I2C bit-count constant (8) SHALL reside in a shared package.
REQ-034 SCL and SDA synchronization SHALL use two instances of the existing sync_reg sub-module; no other sub-module.

Verification
REQ-035 The bench SHALL cover a single write: START, 0xEC, 0xF4, 0x27, STOP -> three ACKs; one RegWr with RegAddr=0xF4, RegWdata=0x27; RegAddr=0xF5 at end.
REQ-036 The bench SHALL cover a burst read: regs F7..F9=0x65,0x5A,0xC0; START 0xEC 0xF7, Sr 0xED, read with ACK,ACK,NACK -> bytes 0x65,0x5A,0xC0 on SDA; three RegRd pulses; RegAddr=0xFA.
REQ-037 The bench SHALL cover an address mismatch: START 0xEE, 0x10, STOP -> SDA never driven, no RegWr, Busy=0.
REQ-038 The bench SHALL cover pointer wrap: START 0xEC 0xFF 0x11 0x22 STOP -> RegWr at 0xFF (0x11) then 0x00 (0x22).
REQ-039 The bench SHALL cover reset mid-read: Rst_n low while driving a 0 bit -> SdaPadEn=1 in the same cycle; the following single-write scenario passes.
REQ-040 The bench SHALL cover an aborted byte: STOP after 4 data bits -> no RegWr, pointer unchanged, IDLE.
